pair_sched: RTL and testbench

Round-robin scheduler that shares one serial "11"-pair Mealy detector among NREQ serial requesters. Each granted requester streams a burst of `len` bits through the shared detector. The scheduler clears the detector before every burst, counts Mealy hits during the burst, and reports the count with the requester ID. It sits between the serial sources and the detector, and owns the detector instance.

---
 rtl/pair_pkg.sv | 16 +
 rtl/pair_det.sv | 28 ++
 rtl/pair_sched.sv | 122 ++++++++++++
 tb/tb_pair_sched.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pair_pkg.sv
// Shared encodings for the round-robin pair scheduler and its "11" detector.
package pair_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLR    = 2'd1,
      RUN    = 2'd2,
      REPORT = 2'd3
   } sched_state_t;

   typedef enum logic {
      DET_A = 1'b0,
      DET_B = 1'b1
   } det_state_t;

endpackage

// File: rtl/pair_det.sv
// Two-state Mealy detector for consecutive "11" pairs on a serial stream.
module pair_det
   import pair_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   input  logic w,
   output logic z
);

   det_state_t state;

   // Clear wins over advance so a new burst always starts from A.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= DET_A;
      end else if (clr) begin
         state <= DET_A;
      end else if (en) begin
         state <= w ? DET_B : DET_A;
      end
   end

   assign z = (state == DET_B) & w;

endmodule

// File: rtl/pair_sched.sv
// Round-robin scheduler sharing one "11" detector among NREQ serial requesters.
module pair_sched
   import pair_pkg::*;
#(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned LEN_W = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NREQ-1:0]  req,
   input  logic [LEN_W-1:0] len,
   input  logic [NREQ-1:0]  bit_in,
   output logic [NREQ-1:0]  grant,
   output logic             done,
   output logic [LEN_W-1:0] hit_count,
   output logic [ID_W-1:0]  hit_id
);

   sched_state_t     state, nxt;
   logic [ID_W-1:0]  id, ptr, pick;
   logic [LEN_W-1:0] len_q, cnt, hit_ctr, hit_nxt;
   logic             det_clr, det_en, det_w, det_z;

   // First set request at or above ptr, wrapping; doubled vector avoids modulo indexing.
   function automatic logic [ID_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                input logic [ID_W-1:0] p);
      logic [2*NREQ-1:0] dbl;
      logic [ID_W-1:0]   win;
      logic              found;
      dbl   = {r, r} >> p;
      win   = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (!found && dbl[k]) begin
            win   = ID_W'((32'(p) + k) % NREQ);
            found = 1'b1;
         end
      end
      return win;
   endfunction

   assign pick    = rr_pick(req, ptr);
   assign det_clr = (state == CLR);
   assign det_en  = (state == RUN);
   assign det_w   = bit_in[id];

   pair_det u_det (
      .clk   (clk),
      .reset (reset),
      .clr   (det_clr),
      .en    (det_en),
      .w     (det_w),
      .z     (det_z)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt     = state;
      hit_nxt = hit_ctr;
      case (state)
         IDLE:    if (req != '0) nxt = CLR;
         CLR: begin
            hit_nxt = '0;
            nxt     = (len_q == '0) ? REPORT : RUN;
         end
         RUN: begin
            if (det_z) hit_nxt = hit_ctr + LEN_W'(1);
            if (cnt == LEN_W'(1)) nxt = REPORT;
         end
         REPORT:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so grant/done line up with CLR/RUN/REPORT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id        <= '0;
         ptr       <= '0;
         len_q     <= '0;
         cnt       <= '0;
         hit_ctr   <= '0;
         grant     <= '0;
         done      <= 1'b0;
         hit_count <= '0;
         hit_id    <= '0;
      end else begin
         if (state == IDLE && req != '0) begin
            id    <= pick;
            len_q <= len;
         end
         if (state == CLR) begin
            cnt <= len_q;
            ptr <= (id == ID_W'(NREQ - 1)) ? '0 : id + ID_W'(1);
         end else if (state == RUN) begin
            cnt <= cnt - LEN_W'(1);
         end
         hit_ctr <= hit_nxt;
         if (nxt == CLR) begin
            grant <= NREQ'(1) << pick;
         end else if (nxt == RUN) begin
            grant <= NREQ'(1) << id;
         end else begin
            grant <= '0;
         end
         done <= (nxt == REPORT);
         if (nxt == REPORT) begin
            hit_count <= hit_nxt;
            hit_id    <= id;
         end
      end
   end

endmodule

// File: tb/tb_pair_sched.sv
// Randomised and directed bench for pair_sched against a burst-level reference model.
module tb_pair_sched;

   localparam int NREQ  = 4;
   localparam int LEN_W = 4;
   localparam int ID_W  = 2;

   logic             clk;
   logic             reset;
   logic [NREQ-1:0]  req;
   logic [LEN_W-1:0] len;
   logic [NREQ-1:0]  bit_in;
   logic [NREQ-1:0]  grant;
   logic             done;
   logic [LEN_W-1:0] hit_count;
   logic [ID_W-1:0]  hit_id;

   int tests  = 0;
   int errors = 0;
   int mptr   = 0;
   int last_cnt = 0;
   int last_id  = 0;

   pair_sched #(.NREQ(NREQ), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .len       (len),
      .bit_in    (bit_in),
      .grant     (grant),
      .done      (done),
      .hit_count (hit_count),
      .hit_id    (hit_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Winner: first requester at or after the model pointer, wrapping around.
   function automatic int model_pick(input logic [NREQ-1:0] r);
      for (int k = 0; k < NREQ; k++) begin
         if (r[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
      end
      return -1;
   endfunction

   // Hits = number of adjacent 1,1 pairs inside the burst.
   function automatic int model_hits(input logic [LEN_W-1:0] l, input logic [15:0] b);
      int h = 0;
      for (int k = 1; k < int'(l); k++) begin
         if (b[k] && b[k-1]) h++;
      end
      return h;
   endfunction

   // Starts in the cycle before IDLE; ends at the negedge of the done cycle.
   task automatic burst(input logic [NREQ-1:0] r, input logic [LEN_W-1:0] l, input logic [15:0] b);
      int w;
      int hits;
      logic [NREQ-1:0] g;
      @(negedge clk);
      w    = model_pick(r);
      hits = model_hits(l, b);
      g    = NREQ'(1) << w;
      req  = r;
      len  = l;
      @(negedge clk);
      check("grant_clr", 32'(grant), 32'(g));
      check("done_clr", 32'(done), 32'(0));
      req    = NREQ'($urandom);
      len    = LEN_W'($urandom);
      bit_in = NREQ'($urandom);
      for (int k = 1; k <= int'(l); k++) begin
         @(negedge clk);
         check("grant_run", 32'(grant), 32'(g));
         check("done_run", 32'(done), 32'(0));
         check("hold_count", 32'(hit_count), 32'(last_cnt));
         bit_in    = NREQ'($urandom);
         bit_in[w] = b[k-1];
         req       = NREQ'($urandom);
      end
      @(negedge clk);
      check("grant_rep", 32'(grant), 32'(0));
      check("done_rep", 32'(done), 32'(1));
      check("hit_count", 32'(hit_count), 32'(hits));
      check("hit_id", 32'(hit_id), 32'(w));
      req      = '0;
      last_cnt = hits;
      last_id  = w;
      mptr     = (w + 1) % NREQ;
   endtask

   initial begin
      reset  = 1'b1;
      req    = '0;
      len    = '0;
      bit_in = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_grant", 32'(grant), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_count", 32'(hit_count), 32'(0));
      check("rst_id", 32'(hit_id), 32'(0));
      reset = 1'b0;

      // Round robin from a fresh pointer: lanes 0,1,2,3,0.
      repeat (5) burst(4'b1111, 4'd2, 16'($urandom));
      // Single burst 1,1,1,0 on lane 0.
      burst(4'b0001, 4'd4, 16'b0000_0000_0000_0111);
      // Zero length on lane 2.
      burst(4'b0100, 4'd0, 16'hFFFF);
      // Max length, all ones.
      burst(4'b0010, 4'd15, 16'hFFFF);
      // Lane 1 ends with a 1, lane 2 then starts 1,0: no carried hit.
      burst(4'b0010, 4'd3, 16'b0000_0000_0000_0110);
      burst(4'b0100, 4'd2, 16'b0000_0000_0000_0001);

      for (int i = 0; i < 40; i++) begin
         logic [NREQ-1:0]  r;
         logic [LEN_W-1:0] l;
         logic [15:0]      b;
         r = NREQ'($urandom_range(1, 15));
         l = LEN_W'($urandom_range(0, 15));
         b = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         burst(r, l, b);
      end

      // Reset after 3 of 8 bits on lane 0.
      @(negedge clk);
      req = 4'b0001;
      len = 4'd8;
      @(negedge clk);
      req = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         bit_in = 4'b1111;
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_rst_grant", 32'(grant), 32'(0));
      check("mid_rst_done", 32'(done), 32'(0));
      check("mid_rst_count", 32'(hit_count), 32'(0));
      check("mid_rst_id", 32'(hit_id), 32'(0));
      @(negedge clk);
      check("mid_rst_nodone", 32'(done), 32'(0));
      reset    = 1'b0;
      mptr     = 0;
      last_cnt = 0;
      last_id  = 0;
      burst(4'b0011, 4'd3, 16'($urandom));
      burst(4'b1000, 4'd3, 16'($urandom));
      burst(4'b1001, 4'd3, 16'($urandom));

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
